// File: rtl/csr_hpm_counter_unit_if.sv
// rtl/csr_hpm_counter_unit_if.sv - CSR access bus between the CSR unit and the HPM counter bank
// master = CSR unit, slave = counter bank.
interface csr_hpm_counter_unit_if;
  logic [11:0] csrNum;
  logic        csrWE;
  logic [31:0] csrWriteData;
  logic [31:0] csrReadData;
  logic        hpmHit;

  modport master (output csrNum, csrWE, csrWriteData, input csrReadData, hpmHit);
  modport slave  (input csrNum, csrWE, csrWriteData, output csrReadData, hpmHit);
endinterface

// File: rtl/csr_hpm_counter_unit.sv
// rtl/csr_hpm_counter_unit.sv - RV32 mhpmcounter/mhpmevent/mcountinhibit bank with registered event increments
// Optional overflow status (hpmovf at 0x801) and ovfIrq enabled by RSD_MARCH_HPM_OVERFLOW_IRQ_EN.
module csr_hpm_counter_unit #(
  parameter int NUM_COUNTERS    = 4,
  parameter int NUM_EVENTS      = 16,
  parameter int EVENT_INC_WIDTH = 3
) (
  input  logic                                  clk,
  input  logic                                  rst,
  csr_hpm_counter_unit_if.slave                 csr,
  input  logic [NUM_EVENTS*EVENT_INC_WIDTH-1:0] eventInc,
  output logic                                  ovfIrq
);
  localparam int SEL_W = $clog2(NUM_EVENTS + 1);

  logic [63:0]                cnt_q [NUM_COUNTERS];
  logic [63:0]                cnt_d [NUM_COUNTERS];
  logic [SEL_W-1:0]           sel_q [NUM_COUNTERS];
  logic [SEL_W-1:0]           sel_d [NUM_COUNTERS];
  logic [EVENT_INC_WIDTH-1:0] inc_q [NUM_COUNTERS];
  logic [EVENT_INC_WIDTH-1:0] inc_d [NUM_COUNTERS];
  logic [NUM_COUNTERS-1:0]    inhibit_q, inhibit_d;

  logic [6:0]  blk;
  logic [4:0]  idx;
  logic [31:0] wdata;
  logic        hit_lo, hit_hi, hit_evt, hit_inh, hit_ovf;
  logic [31:0] rdata;

  assign blk   = csr.csrNum[11:5];
  assign idx   = csr.csrNum[4:0];
  assign wdata = csr.csrWriteData;

  // Indices 0..2 of each block belong to mcycle/minstret territory and are not ours.
  assign hit_lo  = (blk == 7'h58) && (idx >= 5'd3);
  assign hit_hi  = (blk == 7'h5C) && (idx >= 5'd3);
  assign hit_evt = (blk == 7'h19) && (idx >= 5'd3);
  assign hit_inh = (csr.csrNum == 12'h320);
`ifdef RSD_MARCH_HPM_OVERFLOW_IRQ_EN
  logic [NUM_COUNTERS-1:0] ovf_q, ovf_d, carry;
  logic                    irq_q;
  assign hit_ovf = (csr.csrNum == 12'h801);
  assign ovfIrq  = irq_q;
`else
  assign hit_ovf = 1'b0;
  assign ovfIrq  = 1'b0;
`endif

  assign csr.hpmHit      = hit_lo | hit_hi | hit_evt | hit_inh | hit_ovf;
  assign csr.csrReadData = rdata;

  always_comb begin
    rdata = '0;
    for (int k = 0; k < NUM_COUNTERS; k++) begin
      if (idx == 5'(k + 3)) begin
        if (hit_lo)  rdata = cnt_q[k][31:0];
        if (hit_hi)  rdata = cnt_q[k][63:32];
        if (hit_evt) rdata = 32'(sel_q[k]);
      end
      if (hit_inh) rdata[k+3] = inhibit_q[k];
`ifdef RSD_MARCH_HPM_OVERFLOW_IRQ_EN
      if (hit_ovf) rdata[k+3] = ovf_q[k];
`endif
    end
  end

  always_comb begin
    inhibit_d = inhibit_q;
`ifdef RSD_MARCH_HPM_OVERFLOW_IRQ_EN
    carry = '0;
    ovf_d = ovf_q;
`endif
    for (int k = 0; k < NUM_COUNTERS; k++) begin
      inc_d[k] = '0;
      if (sel_q[k] != '0 && !inhibit_q[k]) begin
        for (int e = 0; e < NUM_EVENTS; e++) begin
          if (sel_q[k] == SEL_W'(e + 1)) inc_d[k] = eventInc[e*EVENT_INC_WIDTH +: EVENT_INC_WIDTH];
        end
      end

      // A CSR write to either half replaces the pending increment for that cycle.
      cnt_d[k] = cnt_q[k] + 64'(inc_q[k]);
`ifdef RSD_MARCH_HPM_OVERFLOW_IRQ_EN
      carry[k] = (cnt_d[k] < cnt_q[k]);
`endif
      if (csr.csrWE && idx == 5'(k + 3) && (hit_lo || hit_hi)) begin
        cnt_d[k] = hit_lo ? {cnt_q[k][63:32], wdata} : {wdata, cnt_q[k][31:0]};
`ifdef RSD_MARCH_HPM_OVERFLOW_IRQ_EN
        carry[k] = 1'b0;
`endif
      end

      sel_d[k] = sel_q[k];
      if (csr.csrWE && hit_evt && idx == 5'(k + 3)) begin
        sel_d[k] = (wdata != 32'd0 && wdata <= 32'(NUM_EVENTS)) ? wdata[SEL_W-1:0] : '0;
      end

      if (csr.csrWE && hit_inh) inhibit_d[k] = wdata[k+3];
`ifdef RSD_MARCH_HPM_OVERFLOW_IRQ_EN
      ovf_d[k] = (ovf_q[k] & ~(csr.csrWE & hit_ovf & wdata[k+3])) | carry[k];
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_COUNTERS; k++) begin
        cnt_q[k] <= '0;
        sel_q[k] <= '0;
        inc_q[k] <= '0;
      end
      inhibit_q <= '0;
`ifdef RSD_MARCH_HPM_OVERFLOW_IRQ_EN
      ovf_q <= '0;
      irq_q <= 1'b0;
`endif
    end else begin
      for (int k = 0; k < NUM_COUNTERS; k++) begin
        cnt_q[k] <= cnt_d[k];
        sel_q[k] <= sel_d[k];
        inc_q[k] <= inc_d[k];
      end
      inhibit_q <= inhibit_d;
`ifdef RSD_MARCH_HPM_OVERFLOW_IRQ_EN
      ovf_q <= ovf_d;
      irq_q <= |ovf_q;
`endif
    end
  end
endmodule

// File: tb/tb_csr_hpm_counter_unit.sv
// tb/tb_csr_hpm_counter_unit.sv - scoreboard bench for csr_hpm_counter_unit
module tb_csr_hpm_counter_unit;
  localparam int NC = 4;
  localparam int NE = 16;
  localparam int W  = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NE*W-1:0] eventInc = '0;
  logic            ovfIrq;

  csr_hpm_counter_unit_if bus ();

  csr_hpm_counter_unit #(.NUM_COUNTERS(NC), .NUM_EVENTS(NE), .EVENT_INC_WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .csr      (bus.slave),
    .eventInc (eventInc),
    .ovfIrq   (ovfIrq)
  );

  always #5 clk = ~clk;

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [31:0] exp_q [$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected value is queued when the read is issued and popped once the bus settles.
  task automatic rd(input logic [11:0] addr, input logic [31:0] exp, input logic exp_hit, input string tag);
    logic [31:0] e;
    exp_q.push_back(exp);
    bus.csrNum = addr;
    #1;
    e = exp_q.pop_front();
    check_val(tag, bus.csrReadData, e);
    check_val({tag, "_hit"}, 32'(bus.hpmHit), 32'(exp_hit));
  endtask

  task automatic wr(input logic [11:0] addr, input logic [31:0] data);
    bus.csrNum       = addr;
    bus.csrWriteData = data;
    bus.csrWE        = 1'b1;
    step();
    bus.csrWE        = 1'b0;
  endtask

  function automatic logic [NE*W-1:0] field(input int e, input logic [W-1:0] v);
    logic [NE*W-1:0] r;
    r = '0;
    r[e*W +: W] = v;
    return r;
  endfunction

  logic [31:0] seq_exp [7];

  initial begin
    bus.csrNum = 12'h000;
    bus.csrWE = 1'b0;
    bus.csrWriteData = '0;
    seq_exp = '{32'd0, 32'd0, 32'd3, 32'd6, 32'd9, 32'd12, 32'd12};
    step();
    step();
    rst = 1'b0;

    rd(12'hB03, 32'd0, 1'b1, "rst_cnt_lo");
    rd(12'hB83, 32'd0, 1'b1, "rst_cnt_hi");
    rd(12'h323, 32'd0, 1'b1, "rst_sel");
    rd(12'h320, 32'd0, 1'b1, "rst_inh");
    rd(12'hB1F, 32'd0, 1'b1, "unimpl_k31");
    rd(12'hB02, 32'd0, 1'b0, "minstret_not_hit");
    rd(12'h321, 32'd0, 1'b0, "x321_not_hit");
    check_val("rst_irq", 32'(ovfIrq), 32'd0);
`ifdef RSD_MARCH_HPM_OVERFLOW_IRQ_EN
    rd(12'h801, 32'd0, 1'b1, "rst_ovf");
`else
    rd(12'h801, 32'd0, 1'b0, "no_ovf_reg");
`endif

    wr(12'h323, 32'd2);
    rd(12'h323, 32'd2, 1'b1, "sel_rb2");
    eventInc = field(1, 3'd3);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) step();
      if (i == 4) eventInc = '0;
      rd(12'hB03, seq_exp[i], 1'b1, $sformatf("count_seq%0d", i));
    end
    rd(12'hB83, 32'd0, 1'b1, "count_hi0");

    wr(12'h323, 32'd17);
    rd(12'h323, 32'd0, 1'b1, "sel_illegal");
    eventInc = '1;
    step(); step(); step();
    eventInc = '0;
    rd(12'hB03, 32'd12, 1'b1, "no_count_sel0");
    wr(12'h323, 32'd16);
    rd(12'h323, 32'd16, 1'b1, "sel_rb16");
    wr(12'h323, 32'd2);

    wr(12'hB03, 32'hFFFF_FFFE);
    wr(12'hB83, 32'd0);
    eventInc = field(1, 3'd3);
    step();
    eventInc = '0;
    step();
    rd(12'hB03, 32'h0000_0001, 1'b1, "carry_lo");
    rd(12'hB83, 32'h0000_0001, 1'b1, "carry_hi");
    eventInc = field(1, 3'd3);
    step();
    eventInc = '0;
    wr(12'hB03, 32'h55);
    rd(12'hB03, 32'h55, 1'b1, "wr_wins_lo");
    rd(12'hB83, 32'h1, 1'b1, "wr_wins_hi");
    step();
    rd(12'hB03, 32'h55, 1'b1, "wr_wins_after");

    wr(12'hB1F, 32'h1234);
    rd(12'hB1F, 32'd0, 1'b1, "unimpl_wr_ignored");
    wr(12'h320, 32'hFFFF_FFFF);
    rd(12'h320, 32'h78, 1'b1, "inh_mask");
    wr(12'h320, 32'd0);

    wr(12'hB03, 32'd0);
    wr(12'hB83, 32'd0);
    eventInc = field(1, 3'd1);
    step(); step();
    wr(12'h320, 32'h8);
    rd(12'hB03, 32'd2, 1'b1, "inh_at_write");
    step();
    rd(12'hB03, 32'd3, 1'b1, "inh_inflight");
    step();
    rd(12'hB03, 32'd3, 1'b1, "inh_frozen1");
    step();
    rd(12'hB03, 32'd3, 1'b1, "inh_frozen2");
    rd(12'h320, 32'h8, 1'b1, "inh_rb");
    wr(12'h320, 32'd0);
    rd(12'hB03, 32'd3, 1'b1, "resume0");
    step();
    rd(12'hB03, 32'd3, 1'b1, "resume1");
    step();
    rd(12'hB03, 32'd4, 1'b1, "resume2");
    step();
    rd(12'hB03, 32'd5, 1'b1, "resume3");
    eventInc = '0;
    step(); step();

    wr(12'hB03, 32'hFFFF_FFFF);
    wr(12'hB83, 32'hFFFF_FFFF);
    check_val("wr_no_irq", 32'(ovfIrq), 32'd0);
    eventInc = field(1, 3'd1);
    step();
    eventInc = '0;
    step();
    rd(12'hB03, 32'd0, 1'b1, "wrap_lo");
    rd(12'hB83, 32'd0, 1'b1, "wrap_hi");
    check_val("irq_not_yet", 32'(ovfIrq), 32'd0);
`ifdef RSD_MARCH_HPM_OVERFLOW_IRQ_EN
    rd(12'h801, 32'h8, 1'b1, "ovf_set");
    step();
    check_val("irq_set", 32'(ovfIrq), 32'd1);
    wr(12'h801, 32'h8);
    rd(12'h801, 32'h0, 1'b1, "ovf_clr");
    step();
    check_val("irq_clr", 32'(ovfIrq), 32'd0);
`else
    step();
    check_val("irq_tied0", 32'(ovfIrq), 32'd0);
`endif

    wr(12'hB03, 32'h100);
    eventInc = field(1, 3'd5);
    step();
    rst = 1'b1;
    #1;
    rd(12'hB03, 32'd0, 1'b1, "async_rst_cnt");
    rd(12'h323, 32'd0, 1'b1, "async_rst_sel");
    step();
    rst = 1'b0;
    step(); step();
    rd(12'hB03, 32'd0, 1'b1, "post_rst_cnt");
    eventInc = '0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/csr_hpm_counter_unit.md
Name: csr_hpm_counter_unit

Overview:
- Parametrised bank of RV32 machine hardware performance-monitoring counters (mhpmcounterK/mhpmcounterKh, mhpmeventK, mcountinhibit) for the CSR unit.
- Generalises the fixed mcycle/minstret pair to NUM_COUNTERS selectable-event 64-bit counters with per-cycle multi-count increments.
- Event increments are registered for one pipeline stage before they are added.
- Sits beside the CSR unit, which routes CSR reads and writes here whenever hpmHit is high.

Parameters:
- NUM_COUNTERS, 4, number of counters implemented (indices K = 3 .. 3+NUM_COUNTERS-1); legal range 1..29.
- NUM_EVENTS, 16, number of event sources; selector values 1..NUM_EVENTS are legal.
- EVENT_INC_WIDTH, 3, width of each per-cycle event increment (0..7 per cycle).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- csrNum  in  12  CSR address for the read/write this cycle.
- csrWE  in  1  commit-time CSR write strobe.
- csrWriteData  in  32  already-resolved CSRRW/S/C result.
- csrReadData  out  32  combinational read of csrNum; 0 if not hit.
- hpmHit  out  1  csrNum decodes to a register in this unit.
- eventInc  in  NUM_EVENTS*EVENT_INC_WIDTH  per-event count this cycle; event e occupies bits [e*W +: W] and is selected by value e+1.
- ovfIrq  out  1  overflow interrupt request (optional feature).

Behaviour:
- Address map:
  - mhpmcounterK: 0xB00+K, low 32 bits.
  - mhpmcounterKh: 0xB80+K, high 32 bits.
  - mhpmeventK: 0x320+K.
  - mcountinhibit: 0x320; bits 3..3+NUM_COUNTERS-1 are writable, all other bits read 0.
  - hpmovf: 0x801, exists only with the optional feature.
  - Unimplemented K in 3..31 is still a hit: it reads 0 and ignores writes.
- Reset: all counters, selectors, inhibit bits, the increment stage and the overflow register clear to 0. ovfIrq=0.
- Event selector storage:
  - Values 1..NUM_EVENTS are stored as written.
  - Any other value (including 0) is stored as 0, meaning no event; the register reads back 0.
- Increment pipeline:
  - Stage 1, cycle t: for each counter, the selected eventInc field is latched into incReg[k], or 0 if the selector is 0 or inhibit[k]=1.
  - Stage 2, cycle t+1: cnt[k] <= cnt[k] + incReg[k] as a 64-bit add, zero-extended, wrapping modulo 2^64.
  - Latency from an event to a visible count is 2 edges.
- CSR write timing and priority:
  - A write takes effect at the next edge.
  - A write to the low or high half of counter k replaces that half only; the other half keeps its current value and no carry is propagated.
  - A counter write wins over that counter's stage-2 increment in the same cycle; incReg[k] for that cycle is discarded.
  - A write to a selector or inhibit bit affects stage-1 sampling from the next cycle. An increment already in incReg is still applied.
- Reads:
  - Reads return register state before this cycle's edge, with no bypass of same-cycle writes or increments.
  - mhpmcounterKh reads the current high word; there is no snapshot.
- Reset asserted mid-operation: all state clears immediately, including pending incReg.

Optional Feature:
- Macro: RSD_MARCH_HPM_OVERFLOW_IRQ_EN.
- With the macro defined:
  - A 64-bit wrap of counter k (stage-2 add carry-out) sets sticky bit k+3 of hpmovf.
  - Writing hpmovf clears every bit written as 1 (write-1-to-clear).
  - If a set and a clear of the same bit occur in one cycle, the set wins.
  - ovfIrq is the registered OR of hpmovf, rising one cycle after the wrap edge.
  - A counter write never sets an overflow bit.
- Without the macro:
  - No hpmovf register; 0x801 is not a hit.
  - ovfIrq is tied to 0.

Test Plan:
- Reset, then read 0xB03, 0xB83, 0x323 and 0x320 -> all read 0; ovfIrq=0; hpmHit=1 for each; 0xB1F reads 0 with hpmHit=1.
- Write 0x323=2, then hold eventInc field 1 at 3 for 4 cycles -> 0xB03 reads 3, 6, 9, 12 on successive cycles, starting 2 edges after the first event cycle; the high word stays 0.
- Write 0x323=17 (NUM_EVENTS=16) -> readback 0; no counting with all fields driven to 7.
- Write 0xB03=0xFFFFFFFE and 0xB83=0, then increment by 3 -> low word 0x00000001, high word 0x00000001; a write to 0xB03 in the same cycle as a pending increment leaves exactly the written value.
- Set mcountinhibit bit 3 mid-stream with a constant increment of 1 -> the count advances by at most 1 more (the in-flight incReg), then freezes; clearing the bit resumes counting.
- With RSD_MARCH_HPM_OVERFLOW_IRQ_EN: preset counter 3 to 0xFFFFFFFF_FFFFFFFF, increment by 1 -> counter 0, hpmovf=0x8, ovfIrq=1 next cycle; write 0x801=0x8 -> hpmovf=0 and ovfIrq deasserts.
